fetch_queue: RTL
================

Name: fetch_queue

Overview:
Parametrised successor to the single-register fetch path. It owns the program counter and prefetches instructions from the instruction memory into a DEPTH-entry circular queue, so the IF/ID register drains entries independently of fetch. Decode stalls no longer freeze the PC. A branch, jump or jump-register redirect flushes the queue and restarts fetch at the target. It sits between instructionMemory and IF_ID, and replaces PC + the PC_4 adder.

Parameters:
- WIDTH, 32: instruction, PC and address width.
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: fetch address after reset.
- PC_STEP, 4: byte increment per sequential fetch.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- redirect, input, 1: flush queue and restart fetch (Branch | Jmp | Jmp_Rgst).
- redirect_pc, input, WIDTH: target address, valid when redirect=1.
- fetch_pc, output, WIDTH: address to the instruction memory.
- fetch_inst, input, WIDTH: combinational instruction-memory read data for fetch_pc.
- deq_stall, input, 1: decode hazard stall; holds the head entry.
- out_valid, output, 1: head entry present.
- out_inst, output, WIDTH: head instruction; 0 (NOP) when empty.
- out_pc4, output, WIDTH: head PC+PC_STEP; 0 when empty.
- count, output, log2(DEPTH)+1: occupied entries.
- full, output, 1: count==DEPTH.
- empty, output, 1: count==0.

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC; rd_ptr=wr_ptr=0; count=0. Outputs then read out_valid=0, out_inst=0, out_pc4=0, full=0, empty=1. Reset overrides redirect and all in-flight entries.
- deq = out_valid & ~deq_stall.
- enq = ~redirect & (~full | deq). When full, enqueue is allowed in the same cycle as a dequeue.
- On enq:
  - mem[wr_ptr] <= {fetch_pc+PC_STEP, fetch_inst}.
  - wr_ptr <= wr_ptr+1 mod DEPTH.
  - fetch_pc <= fetch_pc+PC_STEP.
- When full and no dequeue: fetch_pc holds; fetch_inst is ignored.
- On deq: rd_ptr <= rd_ptr+1 mod DEPTH.
- count update: count <= count + enq - deq. It never exceeds DEPTH and never underflows.
- Redirect has priority over enq and deq:
  - fetch_pc <= redirect_pc; rd_ptr=wr_ptr=0; count=0.
  - The head presented that cycle is discarded; the consumer flushes IF/ID from the same redirect.
- Latency: the instruction at fetch_pc in cycle t reaches out_inst in cycle t+1 at the earliest (empty queue, no stall).
- After redirect, the first target instruction appears at t+2 relative to the redirect cycle: one bubble.
- Outputs out_inst, out_pc4 and out_valid are combinational from the head entry, and are forced to 0 when empty.
- Pointer wrap-around is a plain modulo-DEPTH increment. full/empty are decoded from count, never from pointer equality.
- PC arithmetic wraps modulo 2^WIDTH with no overflow flag.
- Queue storage needs no reset; only pointers, count and fetch_pc are reset.

Test Plan:
Bench setup: DEPTH=4, RESET_PC=0, and an instruction-memory model returning fetch_inst = 32'h1000_0000 | fetch_pc.
1. Reset then free run (deq_stall=0):
   - out_valid=0 in the first cycle after reset.
   - Next cycle: out_inst=0x1000_0000, out_pc4=4.
   - Then 0x1000_0004/8, 0x1000_0008/C, one per cycle; count stays 1.
2. Hold deq_stall=1 for 6 cycles:
   - count reaches 4, full=1, fetch_pc holds at 0x10.
   - out_inst stays at the head value; no entry is lost or duplicated.
3. Full queue, deq_stall released:
   - Enqueue and dequeue occur in the same cycle; count stays 4.
   - Output sequence is 0x1000_0000, 0x1000_0004, 0x1000_0008, 0x1000_000C, 0x1000_0010 with no gap.
4. Wrap-around: run 12 sequential entries with deq_stall toggled every other cycle.
   - Outputs remain in strict address order through pointer wrap (indices 3 to 0).
5. Redirect while count=3, redirect_pc=0x40:
   - Next cycle: count=0, empty=1, fetch_pc=0x40.
   - Following cycle: out_inst=0x1000_0040, out_pc4=0x44.
   - No stale entry is ever presented.
   - Also check redirect asserted together with full=1 and deq_stall=1: the same result.
6. rst asserted mid-stream with redirect=1 and count=2:
   - Next cycle: fetch_pc=0, count=0, out_valid=0; the redirect target is ignored.

Source files
------------

// File: rtl/fetch_queue.sv
// Program-counter owner and DEPTH-entry instruction prefetch queue between the
// instruction memory and the IF/ID register; redirects flush and restart fetch.
module fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [WIDTH-1:0]         redirect_pc,
  output logic [WIDTH-1:0]         fetch_pc,
  input  logic [WIDTH-1:0]         fetch_inst,
  input  logic                     deq_stall,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_inst,
  output logic [WIDTH-1:0]         out_pc4,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

  // Handshake: an entry leaves the head when out_valid=1 and deq_stall=0 at a
  // rising edge; the fetch side writes whenever no redirect is pending and a
  // slot is free or is being freed by that same dequeue.

  logic [WIDTH-1:0] inst_mem [DEPTH];
  logic [WIDTH-1:0] pc4_mem  [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] next_seq_pc;
  logic             enq;
  logic             deq;

  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign next_seq_pc = fetch_pc + STEP;

  assign deq = out_valid & ~deq_stall;
  assign enq = ~redirect & (~full | deq);

  assign out_valid = ~empty;
  assign out_inst  = empty ? '0 : inst_mem[rd_ptr];
  assign out_pc4   = empty ? '0 : pc4_mem[rd_ptr];

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      // The head shown this cycle is dropped; IF/ID flushes on the same redirect.
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else begin
      if (enq) begin
        fetch_pc <= next_seq_pc;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Storage is not reset; validity is carried entirely by count.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      inst_mem[wr_ptr] <= fetch_inst;
      pc4_mem[wr_ptr]  <= next_seq_pc;
    end
  end

endmodule
